vga_frame_reader: RTL and testbench

//  Display-side reader of the video memory that MiniAlu programs write (WRITE_ROM path).

---
 rtl/vga_frame_reader.sv | 134 +++++++++++++
 tb/tb_vga_frame_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan generator that reads one colour per cell from the video RAM
// and drives registered RGB and sync outputs, one pixel behind the counters.
module vga_frame_reader #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CLK_DIV    = 2,
    parameter int CELL_SHIFT = 5,
    parameter int ADDR_W     = 9
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oVideoAddress,
    input  logic [2:0]        iVideoData,
    output logic              oRed,
    output logic              oGreen,
    output logic              oBlue,
    output logic              oHSync,
    output logic              oVSync,
    output logic              oFrameStart,
    output logic [9:0]        oColumn,
    output logic [9:0]        oRow
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [19:0] CELLS_PER_ROW = 20'(H_VISIBLE >> CELL_SHIFT);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       col_q, col_d;
    logic [9:0]       row_q, row_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             fs_q, fs_d;
    logic [2:0]       rgb_q, rgb_d;

    logic             tick_s;
    logic             visible_s;
    logic             hs_win_s;
    logic             vs_win_s;
    logic [9:0]       col_clamp_s;
    logic [9:0]       row_clamp_s;

    // Cell address; blanking positions clamp to the last visible cell so the index stays in range
    always_comb begin
        col_clamp_s = (col_q < H_VIS) ? col_q : (H_VIS - 10'd1);
        row_clamp_s = (row_q < V_VIS) ? row_q : (V_VIS - 10'd1);
        oVideoAddress = ADDR_W'(20'(row_clamp_s >> CELL_SHIFT) * CELLS_PER_ROW
                                + 20'(col_clamp_s >> CELL_SHIFT));
    end

    // Pixel divider, scan counters and output latch from the pre-increment position
    always_comb begin
        tick_s    = (div_q == DIV_LAST);
        visible_s = (col_q < H_VIS) && (row_q < V_VIS);
        hs_win_s  = (col_q >= HS_START) && (col_q < HS_END);
        vs_win_s  = (row_q >= VS_START) && (row_q < VS_END);

        div_d   = div_q;
        col_d   = col_q;
        row_d   = row_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        fs_d    = 1'b0;

        if (tick_s) begin
            div_d   = {DIV_W{1'b0}};
            hsync_d = ~hs_win_s;
            vsync_d = ~vs_win_s;
            rgb_d   = visible_s ? iVideoData : 3'b000;
            fs_d    = (col_q == H_LAST) && (row_q == V_LAST);
            if (col_q == H_LAST) begin
                col_d = 10'd0;
                if (row_q == V_LAST) begin
                    row_d = 10'd0;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q   <= {DIV_W{1'b0}};
            col_q   <= 10'd0;
            row_q   <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
            rgb_q   <= 3'b000;
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
        end
    end

    assign oRed        = rgb_q[2];
    assign oGreen      = rgb_q[1];
    assign oBlue       = rgb_q[0];
    assign oHSync      = hsync_q;
    assign oVSync      = vsync_q;
    assign oFrameStart = fs_q;
    assign oColumn     = col_q;
    assign oRow        = row_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full-size instance for line timing, two scaled-down
// instances (divide-by-2 and divide-by-1) so whole frames fit in a short run.
module tb_vga_frame_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] mem [0:511];

    logic [8:0] f_addr, s_addr, d_addr;
    logic [2:0] f_data, s_data, d_data;
    logic       f_r, f_g, f_b, f_hs, f_vs, f_fs;
    logic       s_r, s_g, s_b, s_hs, s_vs, s_fs;
    logic       d_r, d_g, d_b, d_hs, d_vs, d_fs;
    logic [9:0] f_col, f_row, s_col, s_row, d_col, d_row;

    assign f_data = mem[f_addr];
    assign s_data = mem[s_addr];
    assign d_data = mem[d_addr];

    vga_frame_reader dut_full (
        .Clock(clk), .Reset(rst), .oVideoAddress(f_addr), .iVideoData(f_data),
        .oRed(f_r), .oGreen(f_g), .oBlue(f_b), .oHSync(f_hs), .oVSync(f_vs),
        .oFrameStart(f_fs), .oColumn(f_col), .oRow(f_row)
    );

    vga_frame_reader #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(2), .CELL_SHIFT(3), .ADDR_W(9)
    ) dut_small (
        .Clock(clk), .Reset(rst), .oVideoAddress(s_addr), .iVideoData(s_data),
        .oRed(s_r), .oGreen(s_g), .oBlue(s_b), .oHSync(s_hs), .oVSync(s_vs),
        .oFrameStart(s_fs), .oColumn(s_col), .oRow(s_row)
    );

    vga_frame_reader #(
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(1), .CELL_SHIFT(3), .ADDR_W(9)
    ) dut_div1 (
        .Clock(clk), .Reset(rst), .oVideoAddress(d_addr), .iVideoData(d_data),
        .oRed(d_r), .oGreen(d_g), .oBlue(d_b), .oHSync(d_hs), .oVSync(d_vs),
        .oFrameStart(d_fs), .oColumn(d_col), .oRow(d_row)
    );

    // Clock edges since the last edge that sampled Reset high
    int n_cnt;
    always @(posedge clk) begin
        if (rst) n_cnt <= 0;
        else     n_cnt <= n_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    bit active = 1'b0;
    bit done   = 1'b0;

    function automatic int model_addr(input int c, input int r, input int hv,
                                      input int vv, input int sh);
        int cc, rr;
        cc = (c < hv) ? c : hv - 1;
        rr = (r < vv) ? r : vv - 1;
        return (rr >> sh) * (hv >> sh) + (cc >> sh);
    endfunction

    // Expected outputs derived from elapsed cycles: pixel index = cycles / divider,
    // registered outputs describe the pixel before the current one.
    task automatic check_dut(input string nm, input int dv,
                             input int hv, input int hf, input int hsw, input int hb,
                             input int vv, input int vf, input int vsw, input int vb,
                             input int sh,
                             input logic [9:0] col, input logic [9:0] row,
                             input logic [8:0] addr, input logic hs, input logic vs,
                             input logic fs, input logic [2:0] rgb);
        int ht, vt, fr, p, c, r, q, qc, qr, eaddr;
        logic ehs, evs, efs;
        logic [2:0] ergb;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        fr = ht * vt;
        p  = n_cnt / dv;
        c  = (p % fr) % ht;
        r  = (p % fr) / ht;
        eaddr = model_addr(c, r, hv, vv, sh);
        if (p == 0) begin
            ehs = 1'b1; evs = 1'b1; ergb = 3'b000;
        end else begin
            q  = (p - 1) % fr;
            qc = q % ht;
            qr = q / ht;
            ehs  = !(qc >= hv + hf && qc < hv + hf + hsw);
            evs  = !(qr >= vv + vf && qr < vv + vf + vsw);
            ergb = (qc < hv && qr < vv) ? mem[model_addr(qc, qr, hv, vv, sh)] : 3'b000;
        end
        efs = (n_cnt > 0) && (n_cnt % (fr * dv) == 0);
        checks++;
        if (int'(col) != c || int'(row) != r || int'(addr) != eaddr || hs !== ehs ||
            vs !== evs || fs !== efs || rgb !== ergb) begin
            errors++;
            $display("FAIL %s cyc=%0d: got col=%0d row=%0d addr=%0d hs=%b vs=%b fs=%b rgb=%b, expected col=%0d row=%0d addr=%0d hs=%b vs=%b fs=%b rgb=%b",
                     nm, n_cnt, col, row, addr, hs, vs, fs, rgb,
                     c, r, eaddr, ehs, evs, efs, ergb);
        end
    endtask

    task automatic finish_run();
        if (!done) begin
            done = 1'b1;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    endtask

    task automatic check_lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every instance against the model
    task automatic step();
        @(negedge clk);
        if (active) begin
            check_dut("full", 2, 640, 16, 96, 48, 480, 10, 2, 33, 5,
                      f_col, f_row, f_addr, f_hs, f_vs, f_fs, {f_r, f_g, f_b});
            check_dut("small", 2, 64, 4, 8, 4, 48, 2, 2, 3, 3,
                      s_col, s_row, s_addr, s_hs, s_vs, s_fs, {s_r, s_g, s_b});
            check_dut("div1", 1, 64, 4, 8, 4, 48, 2, 2, 3, 3,
                      d_col, d_row, d_addr, d_hs, d_vs, d_fs, {d_r, d_g, d_b});
        end
        if (errors >= 200) finish_run();
    endtask

    initial begin
        int k;
        for (int i = 0; i < 512; i++) mem[i] = 3'(i);

        check_lit("model_addr_639_479", model_addr(639, 479, 640, 480, 5), 299);
        check_lit("model_addr_0_32", model_addr(0, 32, 640, 480, 5), 20);

        // Reset held for three edges
        rst = 1'b1;
        step();
        active = 1'b1;
        step();
        step();
        check_lit("reset_col", int'(f_col), 0);
        check_lit("reset_row", int'(f_row), 0);
        check_lit("reset_syncs", int'({f_hs, f_vs}), 3);
        check_lit("reset_rgb_fs", int'({f_r, f_g, f_b, f_fs}), 0);
        rst = 1'b0;

        // Addressing at the right edge of the first line
        k = 0; step();
        while (!(f_col == 10'd639 && f_row == 10'd0) && k < 3000) begin step(); k++; end
        check_lit("col639_cycle", n_cnt, 1278);
        check_lit("addr_639_0", int'(f_addr), 19);
        step(); step();
        check_lit("rgb_one_pixel_later", int'({f_r, f_g, f_b}), 3);

        // Horizontal sync placement and width
        k = 0; step();
        while (f_hs !== 1'b0 && k < 3000) begin step(); k++; end
        check_lit("hsync_fall_cycle", n_cnt, 1314);
        k = 0; step();
        while (f_hs !== 1'b1 && k < 3000) begin step(); k++; end
        check_lit("hsync_rise_cycle", n_cnt, 1506);
        k = 0; step();
        while (f_row != 10'd1 && k < 3000) begin step(); k++; end
        check_lit("line_length", n_cnt, 1600);
        check_lit("line_wrap_col", int'(f_col), 0);

        // Scaled frame: last visible cell, vertical sync, frame pulse period
        k = 0; step();
        while (!(s_col == 10'd63 && s_row == 10'd47) && k < 10000) begin step(); k++; end
        check_lit("small_last_cell_cycle", n_cnt, 7646);
        check_lit("small_last_cell_addr", int'(s_addr), 47);
        k = 0; step();
        while (s_vs !== 1'b0 && k < 10000) begin step(); k++; end
        check_lit("vsync_fall_cycle", n_cnt, 8002);
        k = 0; step();
        while (s_vs !== 1'b1 && k < 10000) begin step(); k++; end
        check_lit("vsync_rise_cycle", n_cnt, 8322);
        k = 0; step();
        while (s_fs !== 1'b1 && k < 10000) begin step(); k++; end
        check_lit("frame_start_1", n_cnt, 8800);
        k = 0; step();
        while (s_fs !== 1'b1 && k < 10000) begin step(); k++; end
        check_lit("frame_start_2", n_cnt, 17600);

        // Blanking with a white frame buffer
        rst = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 3'b111;
        step();
        rst = 1'b0;
        k = 0; step();
        while (!(s_col == 10'd5 && s_row == 10'd2) && k < 10000) begin step(); k++; end
        check_lit("white_vis_cycle", n_cnt, 330);
        step(); step();
        check_lit("white_visible_rgb", int'({s_r, s_g, s_b}), 7);
        k = 0; step();
        while (!(s_col == 10'd70 && s_row == 10'd2) && k < 10000) begin step(); k++; end
        check_lit("white_blank_cycle", n_cnt, 460);
        step(); step();
        check_lit("white_blank_rgb", int'({s_r, s_g, s_b}), 0);
        repeat (9000) step();

        // Single-cycle reset in the middle of a frame
        k = 0; step();
        while (!(s_row == 10'd30 && s_col == 10'd40) && k < 10000) begin step(); k++; end
        check_lit("midframe_reached", int'(s_row), 30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_lit("midreset_counters", int'({s_col, s_row}), 0);
        check_lit("midreset_syncs", int'({s_hs, s_vs}), 3);
        check_lit("midreset_rgb", int'({s_r, s_g, s_b}), 0);
        check_lit("midreset_full_col", int'(f_col), 0);
        k = 0; step();
        while (s_fs !== 1'b1 && k < 10000) begin step(); k++; end
        check_lit("frame_start_after_reset", n_cnt, 8800);

        finish_run();
    end

endmodule
